lname_mbus_rx_buffer: RTL and testbench

Receive-side buffer directly downstream of the MBus master node. It consumes the node's RX word stream (RX_REQ/RX_ACK four-phase handshake with RX_ADDR, RX_DATA, RX_PEND, RX_BROADCAST, RX_FAIL) and stores message words in a FIFO. Each word is tagged with message-boundary and failure marks. Buffered words are presented to the layer controller on a valid/ready port, which decouples the layer's consumption rate from MBus word timing.

---
 rtl/lname_mbus_rx_buffer_pkg.sv | 38 +++
 rtl/lname_mbus_rx_buffer_if.sv | 37 +++
 rtl/lname_mbus_rx_fifo.sv | 46 ++++
 rtl/lname_mbus_sync2.sv | 16 +
 rtl/lname_mbus_rx_buffer.sv | 122 ++++++++++++
 tb/tb_lname_mbus_rx_buffer.sv | 306 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/lname_mbus_rx_buffer_pkg.sv
// Shared types for the MBus receive buffer: FIFO entry, handshake FSM states, width helpers.
// Bus widths come from MBUS_ADDR_WIDTH / MBUS_DATA_WIDTH and default to 32 bits.
`ifndef MBUS_ADDR_WIDTH
`define MBUS_ADDR_WIDTH 32
`endif
`ifndef MBUS_DATA_WIDTH
`define MBUS_DATA_WIDTH 32
`endif

package lname_mbus_rx_buffer_pkg;
    localparam int ADDR_W = `MBUS_ADDR_WIDTH;
    localparam int DATA_W = `MBUS_DATA_WIDTH;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              first;
        logic              last;
        logic              fail;
        logic              bcast;
    } rx_entry_t;

    localparam int ENTRY_W = $bits(rx_entry_t);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_WAITLOW = 2'd2
    } rx_state_e;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/lname_mbus_rx_buffer_if.sv
// Node-side RX four-phase handshake and layer-side valid/ready stream of the receive buffer.
// RX side: node raises RX_REQ with stable RX_*; buffer raises RX_ACK; node drops RX_REQ; buffer drops RX_ACK.
// OUT side: a head word transfers on every clock edge where OUT_VALID and OUT_READY are both 1.
interface lname_mbus_rx_buffer_if;
    import lname_mbus_rx_buffer_pkg::*;

    logic              RX_REQ;
    logic [ADDR_W-1:0] RX_ADDR;
    logic [DATA_W-1:0] RX_DATA;
    logic              RX_PEND;
    logic              RX_BROADCAST;
    logic              RX_FAIL;
    logic              RX_ACK;

    logic              OUT_VALID;
    logic              OUT_READY;
    logic [ADDR_W-1:0] OUT_ADDR;
    logic [DATA_W-1:0] OUT_DATA;
    logic              OUT_FIRST;
    logic              OUT_LAST;
    logic              OUT_FAIL;
    logic              OUT_BCAST;

    modport slave (
        input  RX_REQ, RX_ADDR, RX_DATA, RX_PEND, RX_BROADCAST, RX_FAIL,
        output RX_ACK,
        output OUT_VALID, OUT_ADDR, OUT_DATA, OUT_FIRST, OUT_LAST, OUT_FAIL, OUT_BCAST,
        input  OUT_READY
    );

    modport master (
        output RX_REQ, RX_ADDR, RX_DATA, RX_PEND, RX_BROADCAST, RX_FAIL,
        input  RX_ACK,
        input  OUT_VALID, OUT_ADDR, OUT_DATA, OUT_FIRST, OUT_LAST, OUT_FAIL, OUT_BCAST,
        output OUT_READY
    );
endinterface

// File: rtl/lname_mbus_rx_fifo.sv
// Parametric entry FIFO: power-of-two storage, wrapping pointers, occupancy count.
module lname_mbus_rx_fifo
    import lname_mbus_rx_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  rx_entry_t                 wr_entry_i,
    output rx_entry_t                 head_o,
    output logic                      valid_o,
    output logic                      full_o,
    output logic [level_w(DEPTH)-1:0] level_o
);
    localparam int PW = ptr_w(DEPTH);
    localparam int LW = level_w(DEPTH);

    rx_entry_t     mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push_i && !pop_i)      level_q <= level_q + LW'(1);
            else if (pop_i && !push_i) level_q <= level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wr_entry_i;
    end

    // Storage is not reset; the head reads as zero whenever nothing is buffered.
    assign valid_o = (level_q != '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
endmodule

// File: rtl/lname_mbus_sync2.sv
// Standard two-flop synchronizer wrapper for single-bit asynchronous levels.
module lname_mbus_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];
endmodule

// File: rtl/lname_mbus_rx_buffer.sv
// MBus receive buffer: synchronizes the node handshake, tags message words and queues them.
// Optional macro LNAME_MBUS_RX_BUFFER_BCAST_FILTER_EN adds ACCEPT_BCAST to discard broadcasts.
module lname_mbus_rx_buffer
    import lname_mbus_rx_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      CLK_EXT,
    input  logic                      RESET,
    lname_mbus_rx_buffer_if.slave     bus,
`ifdef LNAME_MBUS_RX_BUFFER_BCAST_FILTER_EN
    input  logic                      ACCEPT_BCAST,
`endif
    output logic [level_w(DEPTH)-1:0] LEVEL,
    output logic                      OVERFLOW,
    output rx_state_e                 dbg_state_o
);
    rx_state_e         state_q, state_d;
    logic              req_s, fail_s, fail_prev_q;
    logic              in_msg_q, in_msg_d;
    logic              overflow_q, overflow_d;
    logic [ADDR_W-1:0] msg_addr_q, msg_addr_d;
    logic              msg_bcast_q, msg_bcast_d;
    logic              push, pop, fifo_full, full, fifo_valid, keep_word, marker_req;
    rx_entry_t         wr_entry, head;

    lname_mbus_sync2 u_req_sync  (.clk(CLK_EXT), .rst(RESET), .d_i(bus.RX_REQ),  .q_o(req_s));
    lname_mbus_sync2 u_fail_sync (.clk(CLK_EXT), .rst(RESET), .d_i(bus.RX_FAIL), .q_o(fail_s));

    lname_mbus_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(CLK_EXT), .rst(RESET), .push_i(push), .pop_i(pop), .wr_entry_i(wr_entry),
        .head_o(head), .valid_o(fifo_valid), .full_o(fifo_full), .level_o(LEVEL)
    );

    // Room is judged after this cycle's pop so a full FIFO can take a word while draining.
    assign pop        = fifo_valid & bus.OUT_READY;
    assign full       = fifo_full & ~pop;
    assign marker_req = fail_s & ~fail_prev_q & in_msg_q;

`ifdef LNAME_MBUS_RX_BUFFER_BCAST_FILTER_EN
    assign keep_word = ~bus.RX_BROADCAST | ACCEPT_BCAST;
`else
    assign keep_word = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        push        = 1'b0;
        wr_entry    = '0;
        in_msg_d    = in_msg_q;
        overflow_d  = overflow_q;
        msg_addr_d  = msg_addr_q;
        msg_bcast_d = msg_bcast_q;

        if (marker_req) begin
            in_msg_d = 1'b0;
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                push           = 1'b1;
                wr_entry.addr  = msg_addr_q;
                wr_entry.last  = 1'b1;
                wr_entry.fail  = 1'b1;
                wr_entry.bcast = msg_bcast_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // A marker push owns the write port; the word waits one cycle.
                if (req_s && !marker_req) begin
                    if (!keep_word) begin
                        state_d = ST_ACK;
                    end else if (!full) begin
                        state_d        = ST_ACK;
                        push           = 1'b1;
                        wr_entry.addr  = bus.RX_ADDR;
                        wr_entry.data  = bus.RX_DATA;
                        wr_entry.first = ~in_msg_q;
                        wr_entry.last  = ~bus.RX_PEND;
                        wr_entry.bcast = bus.RX_BROADCAST;
                        in_msg_d       = bus.RX_PEND;
                        msg_addr_d     = bus.RX_ADDR;
                        msg_bcast_d    = bus.RX_BROADCAST;
                    end
                end
            end
            ST_ACK:     state_d = ST_WAITLOW;
            ST_WAITLOW: if (!req_s) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_EXT or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            fail_prev_q <= 1'b0;
            in_msg_q    <= 1'b0;
            overflow_q  <= 1'b0;
            msg_addr_q  <= '0;
            msg_bcast_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fail_prev_q <= fail_s;
            in_msg_q    <= in_msg_d;
            overflow_q  <= overflow_d;
            msg_addr_q  <= msg_addr_d;
            msg_bcast_q <= msg_bcast_d;
        end
    end

    assign bus.RX_ACK    = (state_q != ST_IDLE);
    assign bus.OUT_VALID = fifo_valid;
    assign bus.OUT_ADDR  = head.addr;
    assign bus.OUT_DATA  = head.data;
    assign bus.OUT_FIRST = head.first;
    assign bus.OUT_LAST  = head.last;
    assign bus.OUT_FAIL  = head.fail;
    assign bus.OUT_BCAST = head.bcast;
    assign OVERFLOW      = overflow_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_lname_mbus_rx_buffer.sv
// Directed bench for lname_mbus_rx_buffer: node handshake model, stream monitor, per-scenario checks.
module tb_lname_mbus_rx_buffer;
    import lname_mbus_rx_buffer_pkg::*;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int EW    = ENTRY_W;

    logic           clk = 1'b0;
    logic           rst;
    logic [LW-1:0]  level;
    logic           overflow;
    rx_state_e      dbg_state;
`ifdef LNAME_MBUS_RX_BUFFER_BCAST_FILTER_EN
    logic           accept_bcast;
`endif

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];

    lname_mbus_rx_buffer_if bus();

    lname_mbus_rx_buffer #(.DEPTH(DEPTH)) dut (
        .CLK_EXT(clk),
        .RESET(rst),
        .bus(bus),
`ifdef LNAME_MBUS_RX_BUFFER_BCAST_FILTER_EN
        .ACCEPT_BCAST(accept_bcast),
`endif
        .LEVEL(level),
        .OVERFLOW(overflow),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    // ---------------- stream monitor ----------------
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.OUT_VALID === 1'b1 && bus.OUT_READY === 1'b1)
            got_q.push_back({bus.OUT_ADDR, bus.OUT_DATA, bus.OUT_FIRST, bus.OUT_LAST,
                             bus.OUT_FAIL, bus.OUT_BCAST});
    end

    function automatic logic [EW-1:0] mk(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                         input logic f, input logic l, input logic fl,
                                         input logic b);
        return {a, d, f, l, fl, b};
    endfunction

    // ---------------- node driver ----------------
    task automatic req_up(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic pend, input logic bc);
        bus.RX_ADDR      = a;
        bus.RX_DATA      = d;
        bus.RX_PEND      = pend;
        bus.RX_BROADCAST = bc;
        bus.RX_REQ       = 1'b1;
    endtask

    // Cycles until RX_ACK reaches lvl, or -1 when the budget runs out.
    task automatic wait_ack(input logic lvl, input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bus.RX_ACK === lvl) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic send_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic pend, input logic bc, output int up, output int dn);
        req_up(a, d, pend, bc);
        wait_ack(1'b1, 20, up);
        bus.RX_REQ = 1'b0;
        wait_ack(1'b0, 20, dn);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (bus.RX_ACK !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", bus.RX_ACK); end
        checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.OUT_VALID); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (bus.OUT_DATA !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", bus.OUT_DATA); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unicast();
        int up, dn;
        logic [DATA_W-1:0] dv [3];
        dv[0] = 32'hA1; dv[1] = 32'hA2; dv[2] = 32'hA3;
        exp_q.delete(); got_q.delete();
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_word(32'h0000_0012, dv[i], (i < 2), 1'b0, up, dn);
            checks++; if (up !== 3) begin errors++; $display("FAIL unicast_ack_rise%0d: got %0d cycles expected 3", i, up); end
            checks++; if (dn !== 3) begin errors++; $display("FAIL unicast_ack_fall%0d: got %0d cycles expected 3", i, dn); end
            exp_q.push_back(mk(32'h0000_0012, dv[i], (i == 0), (i == 2), 1'b0, 1'b0));
        end
        repeat (4) tick();
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL unicast_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL unicast_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_full();
        int up, dn;
        exp_q.delete(); got_q.delete();
        bus.OUT_READY = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_word(32'h34, 32'h100 + i, 1'b1, 1'b0, up, dn);
            exp_q.push_back(mk(32'h34, 32'h100 + i, (i == 0), 1'b0, 1'b0, 1'b0));
        end
        req_up(32'h34, 32'h108, 1'b1, 1'b0);
        repeat (10) tick();
        checks++; if (bus.RX_ACK !== 1'b0) begin errors++; $display("FAIL full_stall_ack: got %b expected 0", bus.RX_ACK); end
        checks++; if (level !== LW'(8)) begin errors++; $display("FAIL full_level: got %0d expected 8", level); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL full_stall_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        // Word 9 must be taken on the very edge that pops the head.
        bus.OUT_READY = 1'b1;
        wait_ack(1'b1, 20, up);
        checks++; if (up !== 1) begin errors++; $display("FAIL full_accept_on_pop: got %0d cycles expected 1", up); end
        bus.RX_REQ = 1'b0;
        wait_ack(1'b0, 20, dn);
        exp_q.push_back(mk(32'h34, 32'h108, 1'b0, 1'b0, 1'b0, 1'b0));
        send_word(32'h34, 32'h109, 1'b0, 1'b0, up, dn);
        exp_q.push_back(mk(32'h34, 32'h109, 1'b0, 1'b1, 1'b0, 1'b0));
        repeat (12) tick();
        checks++; if (level !== '0) begin errors++; $display("FAIL full_drain_level: got %0d expected 0", level); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL full_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_fail();
        int up, dn;
        exp_q.delete(); got_q.delete();
        bus.OUT_READY = 1'b1;
        send_word(32'h56, 32'hC1, 1'b1, 1'b0, up, dn);
        send_word(32'h56, 32'hC2, 1'b1, 1'b0, up, dn);
        repeat (2) tick();
        bus.RX_FAIL = 1'b1;
        repeat (6) tick();
        bus.RX_FAIL = 1'b0;
        repeat (4) tick();
        send_word(32'h78, 32'hB1, 1'b0, 1'b0, up, dn);
        repeat (3) tick();
        // Outside a message a fail pulse must leave the stream untouched.
        bus.RX_FAIL = 1'b1;
        repeat (6) tick();
        bus.RX_FAIL = 1'b0;
        repeat (4) tick();
        exp_q.push_back(mk(32'h56, 32'hC1, 1'b1, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h56, 32'hC2, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h56, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(mk(32'h78, 32'hB1, 1'b1, 1'b1, 1'b0, 1'b0));
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fail_no_overflow: got %b expected 0", overflow); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL fail_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL fail_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        int up, dn;
        do_reset();
        exp_q.delete(); got_q.delete();
        bus.OUT_READY = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_word(32'h9A, 32'h200 + i, 1'b1, 1'b0, up, dn);
            exp_q.push_back(mk(32'h9A, 32'h200 + i, (i == 0), 1'b0, 1'b0, 1'b0));
        end
        bus.RX_FAIL = 1'b1;
        repeat (6) tick();
        bus.RX_FAIL = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        checks++; if (level !== LW'(8)) begin errors++; $display("FAIL ovf_level: got %0d expected 8", level); end
        bus.OUT_READY = 1'b1;
        repeat (12) tick();
        send_word(32'h9B, 32'h300, 1'b0, 1'b0, up, dn);
        exp_q.push_back(mk(32'h9B, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0));
        repeat (4) tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_bcast();
        int up, dn;
        exp_q.delete(); got_q.delete();
`ifdef LNAME_MBUS_RX_BUFFER_BCAST_FILTER_EN
        accept_bcast  = 1'b0;
        bus.OUT_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_word(32'h0F, 32'hE0 + i, (i < 2), 1'b1, up, dn);
            checks++; if (up !== 3) begin errors++; $display("FAIL bcast_drop_ack%0d: got %0d cycles expected 3", i, up); end
        end
        checks++; if (level !== '0) begin errors++; $display("FAIL bcast_drop_level: got %0d expected 0", level); end
        accept_bcast = 1'b1;
`endif
        bus.OUT_READY = 1'b1;
        send_word(32'h0F, 32'hD1, 1'b1, 1'b1, up, dn);
        checks++; if (up !== 3) begin errors++; $display("FAIL bcast_ack: got %0d cycles expected 3", up); end
        send_word(32'h0F, 32'hD2, 1'b0, 1'b1, up, dn);
        exp_q.push_back(mk(32'h0F, 32'hD1, 1'b1, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk(32'h0F, 32'hD2, 1'b0, 1'b1, 1'b0, 1'b1));
        repeat (4) tick();
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bcast_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bcast_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int up, dn;
        do_reset();
        bus.OUT_READY = 1'b0;
        for (int i = 0; i < 4; i++) send_word(32'hBC, 32'h400 + i, 1'b1, 1'b0, up, dn);
        req_up(32'hBC, 32'h404, 1'b1, 1'b0);
        wait_ack(1'b1, 20, up);
        repeat (2) tick();
        checks++; if (dbg_state !== ST_WAITLOW) begin errors++; $display("FAIL rmid_state: got %0d expected %0d", dbg_state, ST_WAITLOW); end
        checks++; if (level !== LW'(5)) begin errors++; $display("FAIL rmid_level_pre: got %0d expected 5", level); end
        rst = 1'b1;
        #1;
        checks++; if (bus.RX_ACK !== 1'b0) begin errors++; $display("FAIL rmid_ack: got %b expected 0", bus.RX_ACK); end
        checks++; if (level !== '0) begin errors++; $display("FAIL rmid_level: got %0d expected 0", level); end
        checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", bus.OUT_VALID); end
        tick();
        exp_q.delete(); got_q.delete();
        rst = 1'b0;
        // RX_REQ is still high, so the same word is acknowledged again.
        wait_ack(1'b1, 20, up);
        checks++; if (up !== 3) begin errors++; $display("FAIL rmid_reack: got %0d cycles expected 3", up); end
        bus.RX_REQ = 1'b0;
        wait_ack(1'b0, 20, dn);
        bus.OUT_READY = 1'b1;
        repeat (4) tick();
        exp_q.push_back(mk(32'hBC, 32'h404, 1'b1, 1'b0, 1'b0, 1'b0));
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rmid_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst              = 1'b1;
        bus.RX_REQ       = 1'b0;
        bus.RX_ADDR      = '0;
        bus.RX_DATA      = '0;
        bus.RX_PEND      = 1'b0;
        bus.RX_BROADCAST = 1'b0;
        bus.RX_FAIL      = 1'b0;
        bus.OUT_READY    = 1'b0;
`ifdef LNAME_MBUS_RX_BUFFER_BCAST_FILTER_EN
        accept_bcast     = 1'b1;
`endif
        test_reset();
        test_unicast();
        test_full();
        test_fail();
        test_overflow();
        test_bcast();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
